// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding-select
// encodings and the per-stage pipeline record structs.
package hazard_pkg;

  // Upper bound on the register-address width. Records carry addresses at this
  // width; narrower cores zero-extend, which leaves every comparison unchanged.
  localparam int REG_AW_MAX = 16;

  typedef logic [REG_AW_MAX-1:0] regAddr_t;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSel_t;

  // Execute stage: sources are kept so forwarding can be resolved here.
  typedef struct packed {
    regAddr_t rs;
    regAddr_t rt;
    regAddr_t dst;
    logic     rw;
    logic     ld;
  } eRec_t;

  // Memory stage: the load flag marks results that are not ready yet.
  typedef struct packed {
    regAddr_t dst;
    logic     rw;
    logic     ld;
  } mRec_t;

  // Writeback stage.
  typedef struct packed {
    regAddr_t dst;
    logic     rw;
  } wRec_t;

  localparam eRec_t E_BUBBLE = '0;
  localparam mRec_t M_BUBBLE = '0;
  localparam wRec_t W_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// One source-register vs. producing-stage comparison. A hit means the stage
// will write the register the source reads; register 0 never hits when it is
// hardwired.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input  regAddr_t src,
  input  regAddr_t dst,
  input  logic     rw,
  output logic     hit
);

  logic srcIsZero;

  assign srcIsZero = (ZERO_REG != 0) && (src == '0);
  assign hit       = rw && (src == dst) && !srcIsZero;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline with
// branches resolved in D. Tracks E/M/W destination records internally, selects
// E-stage operand sources, selects the D-comparator bypass from M, and raises
// stall/flush on load-use and branch hazards.
// Optional feature: define HAZ_STALL_CNT_EN to add the saturating stall_cnt
// output and its counter.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] dst_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              branch_d,
  input  logic              flush_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Configuration sanity: addresses must fit the package record width and the
  // counter must have at least one bit. An out-of-range setting leaves this
  // block unelaborated-friendly but obviously wrong in the hierarchy.
  if (REG_AW > REG_AW_MAX || CNT_W < 1) begin : gBadConfig
  end

  regAddr_t rsD, rtD, dstD;
  eRec_t    stE;
  mRec_t    stM;
  wRec_t    stW;

  assign rsD  = regAddr_t'(rs_d);
  assign rtD  = regAddr_t'(rt_d);
  assign dstD = regAddr_t'(dst_d);

  // Source/stage comparisons.
  logic hitAeM, hitAeW, hitBeM, hitBeW;
  logic hitAdM, hitBdM, hitAdE, hitBdE;

  hazard_match #(.ZERO_REG(ZERO_REG)) uAeM (.src(stE.rs), .dst(stM.dst), .rw(stM.rw), .hit(hitAeM));
  hazard_match #(.ZERO_REG(ZERO_REG)) uAeW (.src(stE.rs), .dst(stW.dst), .rw(stW.rw), .hit(hitAeW));
  hazard_match #(.ZERO_REG(ZERO_REG)) uBeM (.src(stE.rt), .dst(stM.dst), .rw(stM.rw), .hit(hitBeM));
  hazard_match #(.ZERO_REG(ZERO_REG)) uBeW (.src(stE.rt), .dst(stW.dst), .rw(stW.rw), .hit(hitBeW));
  hazard_match #(.ZERO_REG(ZERO_REG)) uAdM (.src(rsD),    .dst(stM.dst), .rw(stM.rw), .hit(hitAdM));
  hazard_match #(.ZERO_REG(ZERO_REG)) uBdM (.src(rtD),    .dst(stM.dst), .rw(stM.rw), .hit(hitBdM));
  hazard_match #(.ZERO_REG(ZERO_REG)) uAdE (.src(rsD),    .dst(stE.dst), .rw(stE.rw), .hit(hitAdE));
  hazard_match #(.ZERO_REG(ZERO_REG)) uBdE (.src(rtD),    .dst(stE.dst), .rw(stE.rw), .hit(hitBdE));

  // Hazard terms: a load in E cannot feed anything in D; a branch in D also
  // cannot wait on an ALU result in E or a load result still in M.
  logic lwStall, brStall, hazard;

  assign lwStall = id_valid && stE.ld && (hitAdE || hitBdE);
  assign brStall = id_valid && branch_d &&
                   (hitAdE || hitBdE || (stM.ld && (hitAdM || hitBdM)));
  assign hazard  = lwStall || brStall;

  // E-operand source select; M holds the younger result and wins over W.
  fwdSel_t selA, selB;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the if/else chain leaves it unassigned (which would infer a latch).
    selA = FWD_RF;
    selB = FWD_RF;
    if (hitAeM)      selA = FWD_M;
    else if (hitAeW) selA = FWD_W;
    if (hitBeM)      selB = FWD_M;
    else if (hitBeW) selB = FWD_W;
  end

  // Outputs are forced low while reset is held, regardless of D inputs.
  assign fwd_a_e = rst_n ? selA : FWD_RF;
  assign fwd_b_e = rst_n ? selB : FWD_RF;
  assign fwd_a_d = rst_n && hitAdM && !stM.ld;
  assign fwd_b_d = rst_n && hitBdM && !stM.ld;
  assign stall_f = rst_n && hazard;
  assign stall_d = rst_n && hazard;
  assign flush_e = rst_n && hazard;

  // Pipeline record advance: W<=M, M<=E, E<=D or a bubble.
  always_ff @(posedge clk) begin
    // NOTE: the records are a handful of flops, not a memory, so they are all
    // cleared on reset; a stale record would fake a hazard after release.
    if (!rst_n) begin
      stE <= E_BUBBLE;
      stM <= M_BUBBLE;
      stW <= W_BUBBLE;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of
      // the stage ahead of it, so the whole pipe shifts by exactly one slot.
      stW <= '{dst: stM.dst, rw: stM.rw};
      stM <= '{dst: stE.dst, rw: stE.rw, ld: stE.ld};
      if (hazard || flush_d || !id_valid) begin
        stE <= E_BUBBLE;
      end else begin
        stE <= '{rs: rsD, rt: rtD, dst: dstD, rw: regwrite_d, ld: memtoreg_d};
      end
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Count stalled cycles, holding at all-ones once saturated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (hazard && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign stall_cnt = rst_n ? stallCnt : '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl. Two instances share the stimulus: one
// with register 0 hardwired (default) and one with ZERO_REG=0.
// Build with HAZ_STALL_CNT_EN defined to also exercise stall_cnt.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] rs_d, rt_d, dst_d;
  logic       regwrite_d, memtoreg_d, branch_d, flush_d;

  logic [1:0] fwdAE, fwdBE, zFwdAE, zFwdBE;
  logic       fwdAD, fwdBD, zFwdAD, zFwdBD;
  logic       stallF, stallD, flushE, zStallF, zStallD, zFlushE;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stallCnt, zStallCnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(5), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rs_d(rs_d), .rt_d(rt_d), .dst_d(dst_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .branch_d(branch_d),
    .flush_d(flush_d),
    .fwd_a_e(fwdAE), .fwd_b_e(fwdBE), .fwd_a_d(fwdAD), .fwd_b_d(fwdBD),
    .stall_f(stallF), .stall_d(stallD), .flush_e(flushE)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cnt(stallCnt)
`endif
  );

  hazard_fwd_ctrl #(.REG_AW(5), .ZERO_REG(0), .CNT_W(16)) dutZ (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rs_d(rs_d), .rt_d(rt_d), .dst_d(dst_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .branch_d(branch_d),
    .flush_d(flush_d),
    .fwd_a_e(zFwdAE), .fwd_b_e(zFwdBE), .fwd_a_d(zFwdAD), .fwd_b_d(zFwdBD),
    .stall_f(zStallF), .stall_d(zStallD), .flush_e(zFlushE)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cnt(zStallCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkStall(input string tag, input logic exp);
    check({tag, ".stall_f"}, stallF, exp);
    check({tag, ".stall_d"}, stallD, exp);
    check({tag, ".flush_e"}, flushE, exp);
  endtask

  // Present one D-stage slot on the falling edge; outputs are checked 1 ns later,
  // and the following rising edge commits the slot.
  task automatic drive(input logic v, input int rs, input int rt, input int dst,
                       input logic rw, input logic ld, input logic br, input logic fl);
    @(negedge clk);
    id_valid   = v;
    rs_d       = 5'(rs);
    rt_d       = 5'(rt);
    dst_d      = 5'(dst);
    regwrite_d = rw;
    memtoreg_d = ld;
    branch_d   = br;
    flush_d    = fl;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with hazard-looking inputs: every output must stay low.
    rst_n = 1'b0;
    drive(1'b1, 5, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkStall("rst0", 1'b0);
    check("rst0.fwd_a_e", fwdAE, 2'b00);
    check("rst0.fwd_a_d", fwdAD, 1'b0);
    drive(1'b1, 5, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkStall("rst1", 1'b0);
    check("rst1.fwd_b_e", fwdBE, 2'b00);
    check("rst1.fwd_b_d", fwdBD, 1'b0);
`ifdef HAZ_STALL_CNT_EN
    check("rst1.stall_cnt", stallCnt, 16'd0);
`endif
    nop();
    rst_n = 1'b1;
    nop();
    nop();

    // Forward from M: add $3 ; sub rs=$3.
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("add3", 1'b0);
    drive(1'b1, 3, 7, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("sub", 1'b0);
    check("sub.fwd_a_d", fwdAD, 1'b0);
    nop();
    check("subE.fwd_a_e", fwdAE, 2'b10);
    check("subE.fwd_b_e", fwdBE, 2'b00);
    nop();
    nop();

    // Double hazard: $4 written twice, then rt=$4 -> M wins.
    drive(1'b1, 1, 2, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2, 3, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9, 4, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    check("dbl.fwd_b_e", fwdBE, 2'b10);
    check("dbl.fwd_a_e", fwdAE, 2'b00);
    nop();
    nop();

    // Forward from W only: producer two slots ahead.
    drive(1'b1, 1, 2, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2, 3, 21, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11, 2, 22, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    check("wfwd.fwd_a_e", fwdAE, 2'b01);
    nop();
    nop();

    // Branch comparator bypass from an ALU result in M, no stall.
    drive(1'b1, 1, 2, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2, 3, 23, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5, 12, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStall("brM", 1'b0);
    check("brM.fwd_b_d", fwdBD, 1'b1);
    check("brM.fwd_a_d", fwdAD, 1'b0);
    nop();
    nop();

    // Branch right after the ALU op it depends on: one stall cycle.
    drive(1'b1, 1, 2, 14, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 14, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStall("brAlu.c1", 1'b1);
    drive(1'b1, 14, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStall("brAlu.c2", 1'b0);
    check("brAlu.fwd_a_d", fwdAD, 1'b1);
    nop();
    nop();

    // Load-use: lw $5 ; add rs=$5 -> one stall, then forward from W.
    drive(1'b1, 1, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5, 2, 15, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("lwUse.c1", 1'b1);
    drive(1'b1, 5, 2, 15, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("lwUse.c2", 1'b0);
    nop();
    check("lwUse.fwd_a_e", fwdAE, 2'b01);
    nop();
    nop();

    // Branch after load: two stall cycles, then no M bypass.
    drive(1'b1, 1, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 6, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStall("brLw.c1", 1'b1);
    drive(1'b1, 6, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStall("brLw.c2", 1'b1);
    drive(1'b1, 6, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStall("brLw.c3", 1'b0);
    check("brLw.fwd_a_d", fwdAD, 1'b0);
    nop();
    nop();

    // A flushed producer becomes a bubble: nothing to forward.
    drive(1'b1, 1, 2, 18, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 18, 2, 24, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    check("flush.fwd_a_e", fwdAE, 2'b00);
    nop();

    // Flush and stall together: stall outputs still assert.
    drive(1'b1, 1, 0, 17, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 17, 2, 28, 1'b1, 1'b0, 1'b0, 1'b1);
    checkStall("flushStall", 1'b1);
    nop();
    nop();

    // Register 0: hardwired instance ignores it, ZERO_REG=0 instance forwards.
    drive(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 0, 0, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("zero", 1'b0);
    nop();
    check("zero.fwd_a_e", fwdAE, 2'b00);
    check("zero.fwd_b_e", fwdBE, 2'b00);
    check("zeroZ.fwd_a_e", zFwdAE, 2'b10);
    check("zeroZ.fwd_b_e", zFwdBE, 2'b10);
    nop();
    nop();
    drive(1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 0, 3, 25, 1'b1, 1'b0, 1'b0, 1'b0);
    check("zeroLw.stall_d", stallD, 1'b0);
    check("zeroLwZ.stall_d", zStallD, 1'b1);
    nop();
    nop();
    nop();

    // Reset during a load-use stall.
    drive(1'b1, 1, 0, 19, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 19, 2, 26, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("rstMid.pre", 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkStall("rstMid.in", 1'b0);
`ifdef HAZ_STALL_CNT_EN
    check("rstMid.stall_cnt", stallCnt, 16'd0);
`endif
    drive(1'b1, 19, 2, 26, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    checkStall("rstMid.post", 1'b0);
    drive(1'b1, 1, 0, 20, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 20, 2, 27, 1'b1, 1'b0, 1'b0, 1'b0);
    checkStall("rstMid.again", 1'b1);
    nop();
`ifdef HAZ_STALL_CNT_EN
    check("rstMid.stall_cnt1", stallCnt, 16'd1);
`endif
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width (2**REG_AW architectural registers).
REQ-002 SHALL have parameter ZERO_REG, default 1; 1 means register 0 is hardwired and never forwarded or stalled on.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port id_valid, input, 1, the D-stage slot holds a real instruction.
REQ-007 SHALL have ports rs_d and rt_d, input, REG_AW each, D-stage source registers.
REQ-008 SHALL have port dst_d, input, REG_AW, D-stage destination register.
REQ-009 SHALL have ports regwrite_d, memtoreg_d and branch_d, input, 1 each: D-stage writes a register, is a load, resolves a branch in D.
REQ-010 SHALL have port flush_d, input, 1, external kill of the D instruction (jump or taken branch).
REQ-011 SHALL have ports fwd_a_e and fwd_b_e, output, 2 each: E-operand select, 00 regfile, 01 W, 10 M.
REQ-012 SHALL have ports fwd_a_d and fwd_b_d, output, 1 each: D-comparator operand taken from M.
REQ-013 SHALL have ports stall_f, stall_d and flush_e, output, 1 each.
REQ-014 SHALL have port stall_cnt, output, CNT_W, present only under HAZ_STALL_CNT_EN.

Function
REQ-015 SHALL hold internal per-stage records E{rs,rt,dst,rw,ld}, M{dst,rw,ld} and W{dst,rw}, advanced every clock edge: W<=M, M<=E, E<=D.
REQ-016 SHALL load a bubble (rw=0, ld=0, dst=0) into E when stall_d, flush_d or !id_valid is asserted; M and W SHALL advance regardless.
REQ-017 SHALL define match(x,S) as S.rw & (x==S.dst) & !(ZERO_REG & x==0).
REQ-018 SHALL drive fwd_a_e = 10 if match(E.rs,M), else 01 if match(E.rs,W), else 00; fwd_b_e likewise using E.rt. M SHALL take priority when both match.
REQ-019 SHALL drive fwd_a_d = match(rs_d,M) & !M.ld and fwd_b_d = match(rt_d,M) & !M.ld.
REQ-020 SHALL assert lw_stall = id_valid & E.ld & (match(rs_d,E) | match(rt_d,E)).
REQ-021 SHALL assert br_stall = id_valid & branch_d & (match(rs_d,E) | match(rt_d,E) | (M.ld & (match(rs_d,M) | match(rt_d,M)))).
REQ-022 SHALL drive stall_f = stall_d = flush_e = lw_stall | br_stall, combinationally from registered state and D inputs within the same cycle.
REQ-023 A branch depending on a load issued immediately before it SHALL stall for exactly 2 cycles; a branch depending on the preceding ALU op SHALL stall for 1 cycle; a load-use dependency SHALL stall for 1 cycle.
REQ-024 With flush_d and a stall in the same cycle, stall outputs SHALL still assert and E SHALL receive a bubble.
REQ-025 With ZERO_REG=0, register 0 SHALL be treated like any other register.

Reset
REQ-026 On a clock edge with rst_n=0, all stage records SHALL clear to bubble and stall_cnt SHALL clear to 0.
REQ-027 While rst_n=0, all outputs SHALL be 0, independent of the inputs.
REQ-028 Reset asserted mid-stall SHALL drop stall_f, stall_d and flush_e on the same cycle; no stall SHALL persist after release.

Configuration
REQ-029 With HAZ_STALL_CNT_EN defined, stall_cnt SHALL increment on each clock edge where stall_d=1 and SHALL saturate at all-ones.
REQ-030 With HAZ_STALL_CNT_EN undefined, the stall_cnt port and its counter SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-031 Encodings FWD_RF=00, FWD_W=01 and FWD_M=10, plus the stage-record struct typedefs, SHALL live in a shared package hazard_pkg.
REQ-032 The match comparison SHALL be a sub-module, hazard_match, instantiated once per source/stage pair.

Verification
REQ-033 Forward from M: add $3 followed by sub using $3 as rs -> fwd_a_e=10 in the sub's E cycle, no stall.
REQ-034 Double hazard: $4 written in both M and W, E.rt=$4 -> fwd_b_e=10.
REQ-035 Load-use: lw $5 then add with rs=$5 -> stall_f, stall_d and flush_e high for 1 cycle, then fwd_a_e=01.
REQ-036 Branch after load: lw $6 then beq with rs=$6 -> stall for 2 cycles, then fwd_a_d=0 because the value is read from the regfile/W path.
REQ-037 Zero register: writes to $0 with ZERO_REG=1 -> all forwards 00 and no stall; with ZERO_REG=0 -> fwd_a_e=10.
REQ-038 Reset during a load-use stall -> stall outputs drop that cycle; with HAZ_STALL_CNT_EN defined, stall_cnt reads 0, then counts 1 after a single subsequent stall.
